nios_security_duty_out: RTL and testbench
=========================================

# nios_security_duty_out

Avalon-MM slave PWM generator: the output-side counterpart of the duty-cycle input port on the Nios security system bus. Software writes period, duty and control registers. The block drives a single glitch-free PWM line toward the actuator/ESC. Duty and period updates are double-buffered and take effect only on a period boundary, so no runt or stretched pulses are ever emitted.

## Interface
Parameters:
- CNT_W, 32: width of period/duty/counter registers (must be ≤ 32).

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- address  in  2  register index (word addressing).
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- pwm_out  out  1  registered PWM output.

## Operation
- Write occurs when chipselect=1 and write_n=0. Register map:
  - Address 0, DUTY (rw): pending high time in clocks, writedata[CNT_W-1:0].
  - Address 1, PERIOD (rw): pending period in clocks.
  - Address 2, CTRL (rw): bit0 = enable, bit1 = invert, other bits read 0.
  - Address 3, COUNT (ro): current counter value. Writes to it are ignored.
- Active shadows duty_act and period_act are loaded from DUTY and PERIOD:
  - at a wrap, i.e. an edge with enable=1, period_act≠0 and cnt = period_act−1; or
  - on every edge while enable=0 or period_act=0.
- Counter cnt:
  - Held at 0 while enable=0 or period_act=0.
  - Otherwise increments by 1 and wraps to 0 after period_act−1.
- Raw PWM level:
  - raw = (cnt < duty_act) when enable=1 and period_act≠0; otherwise 0.
  - Unsigned compare. duty_act=0 gives constant low. duty_act ≥ period_act gives constant high.
- pwm_out <= raw XOR invert.
  - While disabled, pwm_out rests at the invert level.
  - CTRL changes apply immediately; they are not period-synchronised.
- Simultaneous write and wrap on the same edge: DUTY/PERIOD take the new value. The shadow captures the pre-write value, so the new value applies one period later.
- Enabling from the disabled state: shadows already equal the registers, so the first period starts at cnt=0 on the next edge.
- Disabling mid-period: cnt returns to 0 on the next edge and pwm_out goes to the invert level. There is no period completion.
- Reset (asynchronous, at any time, including mid-period):
  - DUTY, PERIOD, CTRL, duty_act, period_act, cnt, readdata and pwm_out all go to 0.
  - pwm_out is therefore low after reset.

## Timing
- Read:
  - readdata is registered every cycle from the address decode; read latency is 1 clock.
  - readdata shows 0 when chipselect=0.
  - A read issued on the same cycle as a write to that address returns the old value.
- Write: the register holds the new value on the edge where the write is sampled and is visible to a read one cycle later.
- PWM:
  - pwm_out is registered, one clock behind the cnt value it reflects.
  - The high pulse is exactly duty_act clocks per period of period_act clocks.
- Duty/period change latency: a value is applied at the first wrap strictly after the write edge, at most period_act clocks later.

## Test plan
- Basic PWM:
  - Stimulus: reset, write PERIOD=10, DUTY=3, CTRL=1.
  - Required: pwm_out repeats 3 clocks high, 7 low; COUNT reads cycle 0..9.
- Mid-period update:
  - Stimulus: during the period with cnt=4, write DUTY=7.
  - Required: the current period keeps 3 high; the next period shows 7 high, 3 low, with no glitch.
- Write on the wrap edge:
  - Stimulus: write DUTY=5 on the edge where cnt=9.
  - Required: the following period still uses the old duty; the period after that uses 5.
- Boundary duties:
  - Stimulus: DUTY=0, then DUTY=12 with PERIOD=10, then PERIOD=0.
  - Required: constant low, then constant high, then constant low with COUNT=0.
- Invert and enable:
  - Stimulus: CTRL=3, then CTRL=2.
  - Required: with CTRL=3, pwm_out is 3 low / 7 high; with CTRL=2, pwm_out=1 steady and COUNT=0.
- Reset and readback:
  - Stimulus: assert reset_n=0 asynchronously mid-pulse, then read addresses 0–3.
  - Required: pwm_out goes to 0 immediately; every read returns 0 with 1-cycle latency; after writing DUTY=0xA5, a read returns 0xA5 one cycle after the read is issued.

Source files
------------

// File: rtl/nios_security_duty_out_if.sv
// Avalon-MM register port of the duty-cycle output block.
// Bus handshake: a write is accepted on any clock edge that samples chipselect=1
// and write_n=0, with no wait states; readdata is valid one clock after the edge
// that sampled chipselect/address, and reads 0 when chipselect was low.
interface nios_security_duty_out_if;
   logic        chipselect;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output chipselect,
      output address,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  chipselect,
      input  address,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_security_duty_out.sv
// Avalon-MM PWM generator with double-buffered duty/period that switch only on a
// period boundary, so the output never shows runt or stretched pulses.
module nios_security_duty_out #(
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   nios_security_duty_out_if.slave  bus,
   output logic                     pwm_out
);

   localparam logic [1:0] ADDR_DUTY   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] duty_reg;
   logic [CNT_W-1:0] period_reg;
   logic [1:0]       ctrl_reg;
   logic [CNT_W-1:0] duty_act;
   logic [CNT_W-1:0] period_act;
   logic [CNT_W-1:0] cnt;

   logic             wr_en;
   logic             enable;
   logic             invert;
   logic             running;
   logic             wrap;
   logic             shadow_load;
   logic             raw;
   logic [CNT_W-1:0] cnt_next;
   logic [31:0]      rd_mux;

   assign wr_en  = bus.chipselect && !bus.write_n;
   assign enable = ctrl_reg[0];
   assign invert = ctrl_reg[1];

   // Counting only happens with a non-zero active period; otherwise the block idles at 0.
   assign running     = enable && (period_act != '0);
   assign wrap        = running && (cnt == (period_act - CNT_ONE));
   assign shadow_load = wrap || !running;
   assign raw         = running && (cnt < duty_act);

   always_comb begin
      cnt_next = '0;
      if (running && !wrap) begin
         cnt_next = cnt + CNT_ONE;
      end
   end

   // Software-visible registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_reg   <= '0;
         period_reg <= '0;
         ctrl_reg   <= '0;
      end else if (wr_en) begin
         case (bus.address)
            ADDR_DUTY:   duty_reg   <= bus.writedata[CNT_W-1:0];
            ADDR_PERIOD: period_reg <= bus.writedata[CNT_W-1:0];
            ADDR_CTRL:   ctrl_reg   <= bus.writedata[1:0];
            default:     ;
         endcase
      end
   end

   // Shadows sample the pre-write register values, so a write on a wrap edge waits a period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_act   <= '0;
         period_act <= '0;
      end else if (shadow_load) begin
         duty_act   <= duty_reg;
         period_act <= period_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         pwm_out <= raw ^ invert;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_DUTY:   rd_mux[CNT_W-1:0] = duty_reg;
         ADDR_PERIOD: rd_mux[CNT_W-1:0] = period_reg;
         ADDR_CTRL:   rd_mux[1:0]       = ctrl_reg;
         ADDR_COUNT:  rd_mux[CNT_W-1:0] = cnt;
         default:     rd_mux            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else if (bus.chipselect) begin
         bus.readdata <= rd_mux;
      end else begin
         bus.readdata <= '0;
      end
   end

endmodule

// File: tb/tb_nios_security_duty_out.sv
// Directed bench for the PWM block: a vector table of steady-state waveforms
// plus hand-written sequences for update timing, reset and readback.
module tb_nios_security_duty_out;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pwm_out;

   nios_security_duty_out_if bus ();

   nios_security_duty_out #(.CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .pwm_out (pwm_out)
   );

   // clock / reset
   always #5 clk = ~clk;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] cap;
   logic [31:0] rd;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] duty;
      logic [31:0] period;
      logic [31:0] ctrl;
      logic [23:0] pat;
      logic [31:0] count;
      logic [31:0] ctrl_rb;
   } vec_t;

   vec_t vt[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // driver: called at a falling edge, drives one rising edge, returns at the next falling edge
   task automatic cycle(input logic cs, input logic [1:0] a, input logic wn, input logic [31:0] wd);
      bus.chipselect = cs;
      bus.address    = a;
      bus.write_n    = wn;
      bus.writedata  = wd;
      @(negedge clk);
      cap = {cap[30:0], pwm_out};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 1'b1, 32'd0);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      cycle(1'b1, a, 1'b0, d);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      cycle(1'b1, a, 1'b1, 32'd0);
      d = bus.readdata;
   endtask

   // scoreboard
   task automatic read_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      bus_read(a, rd);
      check(name, rd, exp_q.pop_front());
   endtask

   // leaves the block freshly enabled with cnt=0 at the returning falling edge
   task automatic start_pwm(input logic [31:0] d, input logic [31:0] p, input logic [31:0] c);
      bus_write(2'd2, 32'd0);
      idle(1);
      bus_write(2'd0, d);
      bus_write(2'd1, p);
      bus_write(2'd2, c);
      cap = '0;
   endtask

   initial begin
      vt[0] = '{32'd3,  32'd10, 32'd1,      24'b111000000011100000001110, 32'd4, 32'd1};
      vt[1] = '{32'd0,  32'd10, 32'd1,      24'h000000,                   32'd4, 32'd1};
      vt[2] = '{32'd12, 32'd10, 32'd1,      24'hFFFFFF,                   32'd4, 32'd1};
      vt[3] = '{32'd3,  32'd0,  32'd1,      24'h000000,                   32'd0, 32'd1};
      vt[4] = '{32'd3,  32'd10, 32'd3,      24'b000111111100011111110001, 32'd4, 32'd3};
      vt[5] = '{32'd3,  32'd10, 32'd2,      24'hFFFFFF,                   32'd0, 32'd2};
      vt[6] = '{32'd10, 32'd10, 32'd1,      24'hFFFFFF,                   32'd4, 32'd1};
      vt[7] = '{32'd1,  32'd4,  32'd1,      24'b100010001000100010001000, 32'd0, 32'd1};
      vt[8] = '{32'd9,  32'd10, 32'h0000_00F1, 24'b111111111011111111101111, 32'd4, 32'd1};

      bus.chipselect = 1'b0;
      bus.address    = 2'd0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'd0;
      cap            = '0;

      repeat (3) @(negedge clk);
      check("reset_pwm", {31'd0, pwm_out}, 32'd0);
      check("reset_readdata", bus.readdata, 32'd0);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) read_expect($sformatf("reset_reg%0d", a), 2'(a), 32'd0);

      // steady-state waveforms
      for (int v = 0; v < 9; v++) begin
         start_pwm(vt[v].duty, vt[v].period, vt[v].ctrl);
         idle(24);
         check($sformatf("vec%0d_pattern", v), {8'd0, cap[23:0]}, {8'd0, vt[v].pat});
         read_expect($sformatf("vec%0d_count", v), 2'd3, vt[v].count);
         read_expect($sformatf("vec%0d_ctrl", v), 2'd2, vt[v].ctrl_rb);
      end

      // COUNT walks 0..9 and wraps
      start_pwm(32'd3, 32'd10, 32'd1);
      for (int k = 0; k < 12; k++) read_expect($sformatf("count_walk%0d", k), 2'd3, 32'(k % 10));

      // duty written mid-period applies from the next period
      start_pwm(32'd3, 32'd10, 32'd1);
      idle(4);
      bus_write(2'd0, 32'd7);
      idle(25);
      check("mid_period_update", {2'd0, cap[29:0]}, {2'd0, 30'b1110000000_1111111000_1111111000});

      // duty written on the wrap edge waits one extra period
      start_pwm(32'd3, 32'd10, 32'd1);
      idle(9);
      bus_write(2'd0, 32'd5);
      idle(20);
      check("wrap_edge_write", {2'd0, cap[29:0]}, {2'd0, 30'b1110000000_1110000000_1111100000});
      read_expect("wrap_edge_duty_rb", 2'd0, 32'd5);

      // asynchronous reset during a high pulse
      start_pwm(32'd3, 32'd10, 32'd1);
      idle(1);
      check("pulse_before_reset", {31'd0, pwm_out}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check("pwm_async_reset", {31'd0, pwm_out}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) read_expect($sformatf("post_reset_reg%0d", a), 2'(a), 32'd0);

      // readback and read-during-write
      bus_write(2'd0, 32'h0000_00A5);
      idle(1);
      check("readdata_no_cs", bus.readdata, 32'd0);
      read_expect("duty_a5", 2'd0, 32'h0000_00A5);
      cycle(1'b1, 2'd0, 1'b0, 32'h0000_0011);
      check("read_during_write_old", bus.readdata, 32'h0000_00A5);
      read_expect("duty_after_write", 2'd0, 32'h0000_0011);
      bus_write(2'd3, 32'h0000_0055);
      read_expect("count_write_ignored", 2'd3, 32'd0);
      read_expect("period_rb", 2'd1, 32'd0);

      // final report
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
